// File: rtl/argmax_stream.sv
// Streaming argmax: tracks the running maximum of a frame of signed scores and
// presents the winning index, its one-hot form and the max score until accepted.
module argmax_stream #(
  parameter  int NUM_CLASSES = 10,
  parameter  int DATA_W      = 32,
  localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_idx,
  output logic [NUM_CLASSES-1:0]   out_onehot,
  output logic [DATA_W-1:0]        out_max,
  output logic                     out_err
);

  localparam int CNT_W = $clog2(NUM_CLASSES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t state;
  state_t next_state;

  logic signed [DATA_W-1:0] max_r;
  logic [IDX_W-1:0]         idx_r;
  logic [CNT_W-1:0]         cnt_r;

  logic signed [DATA_W-1:0] cand_max;
  logic [IDX_W-1:0]         cand_idx;
  logic [CNT_W-1:0]         cand_cnt;
  logic                     accept;
  logic                     full;
  logic                     frame_end;

  logic [IDX_W-1:0]         res_idx;
  logic [NUM_CLASSES-1:0]   res_onehot;
  logic [DATA_W-1:0]        res_max;
  logic                     res_err;

  // Ready is forced low while reset is asserted, not just while holding a result.
  assign in_ready = rst && (state != HOLD);
  assign accept   = in_valid && in_ready;

  // The first beat of a frame always loads; later beats replace only on a strict win.
  always_comb begin
    cand_max = max_r;
    cand_idx = idx_r;
    cand_cnt = cnt_r;
    if (state == IDLE) begin
      cand_max = in_data;
      cand_idx = '0;
      cand_cnt = CNT_W'(1);
    end else begin
      if (in_data > max_r) begin
        cand_max = in_data;
        cand_idx = IDX_W'(cnt_r);
      end
      cand_cnt = cnt_r + CNT_W'(1);
    end
  end

  assign full      = (cand_cnt == CNT_W'(NUM_CLASSES));
  assign frame_end = accept && (in_last || full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = frame_end ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (frame_end) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Running accumulator; only touched on accepted beats so idle X data never leaks in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_r <= '0;
      idx_r <= '0;
      cnt_r <= '0;
    end else if (accept) begin
      max_r <= cand_max;
      idx_r <= cand_idx;
      cnt_r <= frame_end ? '0 : cand_cnt;
    end
  end

  // Result registers: loaded by the closing beat, cleared once downstream takes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_idx    <= '0;
      res_onehot <= '0;
      res_max    <= '0;
      res_err    <= 1'b0;
    end else if (frame_end) begin
      res_idx    <= cand_idx;
      res_onehot <= {{(NUM_CLASSES-1){1'b0}}, 1'b1} << cand_idx;
      res_max    <= cand_max;
      res_err    <= (in_last != full);
    end else if ((state == HOLD) && out_ready) begin
      res_idx    <= '0;
      res_onehot <= '0;
      res_max    <= '0;
      res_err    <= 1'b0;
    end
  end

  assign out_valid  = (state == HOLD);
  assign out_idx    = res_idx;
  assign out_onehot = res_onehot;
  assign out_max    = res_max;
  assign out_err    = res_err;

endmodule

// File: tb/tb_argmax_stream.sv
// Randomised bench for argmax_stream: a queue-based frame model predicts each
// result, a per-cycle compare process checks the DUT, and directed frames pin the model.
module tb_argmax_stream;

  localparam int N  = 10;
  localparam int DW = 32;
  localparam int IW = 4;

  localparam int RDY_RANDOM = 0;
  localparam int RDY_LOW    = 1;
  localparam int RDY_HIGH   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [IW-1:0]        out_idx;
  logic [N-1:0]         out_onehot;
  logic [DW-1:0]        out_max;
  logic                 out_err;

  int checks = 0;
  int errors = 0;
  int rdy_mode = RDY_HIGH;

  logic signed [DW-1:0] fb [0:15];

  // Model state
  logic signed [DW-1:0] beats [$];
  logic                 exp_valid = 1'b0;
  int                   exp_idx   = 0;
  logic [DW-1:0]        exp_max   = '0;
  logic                 exp_err   = 1'b0;

  argmax_stream #(.NUM_CLASSES(N), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .out_max    (out_max),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect accepted scores, and when the frame closes pick
  // the first position holding the largest signed value.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats.delete();
      exp_valid = 1'b0;
      exp_idx   = 0;
      exp_max   = '0;
      exp_err   = 1'b0;
    end else if (exp_valid) begin
      if (out_ready) exp_valid = 1'b0;
    end else if (in_valid) begin
      beats.push_back(in_data);
      if (in_last || beats.size() == N) begin
        int best;
        best = 0;
        for (int i = 1; i < beats.size(); i++)
          if (beats[i] > beats[best]) best = i;
        exp_idx   = best;
        exp_max   = beats[best];
        exp_err   = (in_last != (beats.size() == N));
        exp_valid = 1'b1;
        beats.delete();
      end
    end
  end

  always @(negedge clk) begin
    case (rdy_mode)
      RDY_LOW:  out_ready = 1'b0;
      RDY_HIGH: out_ready = 1'b1;
      default:  out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_onehot", out_onehot, 0);
      chk("rst_out_max", out_max, 0);
      chk("rst_out_err", out_err, 0);
    end else begin
      chk("out_valid", out_valid, exp_valid);
      chk("in_ready", in_ready, !exp_valid);
      if (exp_valid) begin
        logic [N-1:0] oh;
        oh = '0;
        oh[exp_idx] = 1'b1;
        chk("out_idx", out_idx, exp_idx);
        chk("out_onehot", out_onehot, oh);
        chk("out_max", out_max, exp_max);
        chk("out_err", out_err, exp_err);
      end
    end
  end

  task automatic applyStimulus(input int n, input int last_at, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      int tries;
      @(negedge clk);
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 'x;
        in_last  = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = fb[i];
      in_last  = (i == last_at);
      tries = 0;
      while (exp_valid && tries < 50) begin
        @(negedge clk);
        tries++;
      end
      if (exp_valid) begin
        checks++;
        errors++;
        $display("[TB] FAIL ready_wait: got in_ready %0b expected 1 within 50 cycles", in_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'b0;
  endtask

  task automatic checkOutput(input int idx, input logic [DW-1:0] mx, input logic err);
    logic [N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    chk("lit_model_idx", exp_idx, idx);
    chk("lit_model_max", exp_max, mx);
    chk("lit_model_err", exp_err, err);
    chk("lit_out_valid", out_valid, 1);
    chk("lit_out_idx", out_idx, idx);
    chk("lit_out_onehot", out_onehot, oh);
    chk("lit_out_max", out_max, mx);
    chk("lit_out_err", out_err, err);
  endtask

  task automatic drain();
    int tries;
    rdy_mode = RDY_HIGH;
    tries = 0;
    while (exp_valid && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (exp_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got out_valid %0b expected 0 within 20 cycles", out_valid);
    end
  endtask

  task automatic load_frame_a();
    logic signed [DW-1:0] a [0:9];
    a = '{3, 7, -2, 7, 1, 0, 5, 6, 2, 7};
    for (int i = 0; i < 10; i++) fb[i] = a[i];
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    // Basic frame, ties keep the lowest index
    load_frame_a();
    applyStimulus(10, 9, 0);
    checkOutput(1, 32'd7, 1'b0);
    drain();

    // All most-negative scores
    for (int i = 0; i < 10; i++) fb[i] = 32'sh80000000;
    applyStimulus(10, 9, 0);
    checkOutput(0, 32'h80000000, 1'b0);
    drain();

    // Short frame flags an error, the following full frame does not
    fb[0] = 1; fb[1] = 2; fb[2] = 9;
    applyStimulus(3, 2, 0);
    checkOutput(2, 32'd9, 1'b1);
    drain();
    begin
      logic signed [DW-1:0] b [0:9];
      b = '{4, -1, 3, 8, 20, 100, -7, 100, 0, 2};
      for (int i = 0; i < 10; i++) fb[i] = b[i];
    end
    applyStimulus(10, 9, 0);
    checkOutput(5, 32'd100, 1'b0);
    drain();

    // Missing last: frame closes on the tenth beat
    for (int i = 0; i < 9; i++) fb[i] = i + 1;
    fb[9] = 50;
    applyStimulus(10, -1, 0);
    checkOutput(9, 32'd50, 1'b1);
    drain();

    // One-beat frame
    fb[0] = -5;
    applyStimulus(1, 0, 0);
    checkOutput(0, 32'hFFFFFFFB, 1'b1);
    drain();

    // Back-pressure: result held while upstream keeps offering data
    rdy_mode = RDY_LOW;
    load_frame_a();
    applyStimulus(10, 9, 0);
    checkOutput(1, 32'd7, 1'b0);
    in_valid = 1'b1;
    in_data  = 123;
    in_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_idx", out_idx, 1);
      chk("bp_out_max", out_max, 7);
    end
    in_valid = 1'b0;
    in_data  = 'x;
    rdy_mode = RDY_HIGH;
    repeat (2) @(negedge clk);
    chk("bp_released_valid", out_valid, 0);
    chk("bp_released_ready", in_ready, 1);

    // Reset while a result is held
    rdy_mode = RDY_LOW;
    load_frame_a();
    applyStimulus(10, 9, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_idx", out_idx, 0);
    chk("arst_out_onehot", out_onehot, 0);
    chk("arst_out_max", out_max, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    rdy_mode = RDY_HIGH;

    // Reset after four beats of a frame, then a clean frame
    for (int i = 0; i < 10; i++) fb[i] = 1000 + i;
    applyStimulus(4, -1, 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in_ready", in_ready, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    load_frame_a();
    applyStimulus(10, 9, 0);
    checkOutput(1, 32'd7, 1'b0);
    drain();

    // Randomised frames with gaps and random back-pressure
    rdy_mode = RDY_RANDOM;
    for (int f = 0; f < 60; f++) begin
      int last_at;
      int len;
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0:       fb[i] = 32'sh80000000;
          1:       fb[i] = 32'sh7FFFFFFF;
          2:       fb[i] = $urandom;
          default: fb[i] = $signed($urandom_range(0, 8)) - 4;
        endcase
      end
      last_at = $urandom_range(0, N);
      len = (last_at == N) ? N : last_at + 1;
      applyStimulus(len, (last_at == N) ? -1 : last_at, 25);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/argmax_stream.md
Name: argmax_stream

Overview:
- Sequential, parametrised argmax unit for the classifier output stage.
- Accepts one signed score per cycle over a valid/ready stream and tracks the running maximum over a frame of NUM_CLASSES scores.
- At frame end, emits the winning class as an index, a one-hot vector and the max score, held until accepted downstream.
- Adds framing checks and back-pressure.

Parameters:
- NUM_CLASSES, 10, scores per frame; legal range 2..256.
- DATA_W, 32, score width; scores are two's-complement signed.
- IDX_W, $clog2(NUM_CLASSES), width of the class index (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  score beat valid.
- in_ready  output  1  unit can accept a beat.
- in_data  input  DATA_W  signed score.
- in_last  input  1  marks the final beat of a frame.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_idx  output  IDX_W  index of the winning class.
- out_onehot  output  NUM_CLASSES  one-hot of out_idx.
- out_max  output  DATA_W  winning score.
- out_err  output  1  frame length error on this result.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, beat count=0.
  - in_ready=0 while rst=0.
  - out_valid=0, out_idx=0, out_onehot=0, out_max=0, out_err=0.
  - Reset mid-frame or while a result is held discards everything; no partial result is emitted.
- A beat is accepted on a rising edge where in_valid && in_ready.
- States:
  - IDLE:
    - in_ready=1.
    - First accepted beat loads max=in_data, idx=0, cnt=1, and moves to ACCUM.
    - If that beat also ends the frame, go straight to HOLD.
  - ACCUM:
    - in_ready=1.
    - Each accepted beat at position cnt replaces max/idx only if in_data > max (strict, signed), so ties keep the lowest index.
    - cnt increments on each accepted beat.
  - HOLD:
    - in_ready=0, out_valid=1; outputs stable.
    - On out_valid && out_ready: out_valid drops next cycle and state returns to IDLE.
    - No bubble-free overlap: the next frame's first beat can be accepted the cycle after the handshake.
- Frame end is the accepted beat where in_last=1 OR cnt reaches NUM_CLASSES, whichever comes first.
  - The compare of the final beat is included in the result.
  - Registered outputs go valid the cycle after the final beat is accepted (latency 1).
- out_err=1 when the frame ends with in_last=1 before beat NUM_CLASSES (short frame), or when beat NUM_CLASSES arrives with in_last=0 (missing last).
  - In both cases the result still reflects the beats received.
  - A 1-beat frame with in_last=1 gives idx=0 and err=1.
- out_onehot has exactly one bit set when out_valid=1, and equals 1<<out_idx.
- in_valid with in_ready=0 (HOLD) is ignored; the upstream must hold its data.
- Signed extremes: the most negative value 2^(DATA_W-1) negated is a legal score and compares correctly. No implicit initial max sentinel is used; the first beat always loads.
- in_data and in_last are ignored when in_valid=0.
- X on in_data while in_valid=0 must not propagate into state.

Test Plan:
- Reset, then frame [3,7,-2,7,1,0,5,6,2,7] with in_last on beat 9 -> one cycle later out_valid=1, out_idx=1, out_onehot=10'b0000000010, out_max=7, out_err=0.
- All ten scores = -2147483648, in_last on beat 9 -> out_idx=0, out_max=0x80000000, out_err=0.
- Frame [1,2,9] with in_last on beat 2 -> out_idx=2, out_max=9, out_err=1; the next full frame gives err=0.
- Ten beats with in_last never asserted, max 50 at beat 9 -> frame closes after beat 9, out_idx=9, out_err=1.
- Hold out_ready=0 for 5 cycles after a result while in_valid=1 with new data -> in_ready=0 and outputs unchanged throughout; after out_ready=1, out_valid falls and the new frame starts in IDLE.
- Assert rst=0 asynchronously after 4 beats of a frame -> all outputs immediately 0; after release, a fresh full frame yields the correct result with no contamination from the aborted beats.
